sreg_sample_packer: RTL and testbench
=====================================

Name: sreg_sample_packer

Overview:
Downstream stage of multi_bit_sreg. Consumes the delayed DW-bit sample stream qualified by the same ce strobe and packs PACK consecutive samples into one wide word. Completed words go to a 2-entry output buffer with a valid/ready handshake. Supports an explicit flush of a partial word and a sticky overflow flag for words lost under backpressure.

Parameters:
DW, 4, sample width; matches multi_bit_sreg DW.
PACK, 4, samples per output word; must be >= 2.
CW, $clog2(PACK+1), width of the m_cnt field (derived; do not override).

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  synchronous reset, active low.
ce  input  1  sample strobe; din is captured on a cycle where ce=1.
din  input  DW  sample data; connects to multi_bit_sreg dout.
flush  input  1  emit the partial word now.
m_valid  output  1  the output word at the buffer head is valid.
m_ready  input  1  the consumer accepts the head word.
m_data  output  DW*PACK  packed word; first sample in bits [DW-1:0].
m_cnt  output  CW  number of valid samples in m_data (1..PACK).
ovf  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset: rst_n=0 sampled at posedge.
  - Clears the accumulator, cnt, buffer, m_valid, m_data, m_cnt and ovf to 0.
  - Reset has priority over ce and flush.
  - A partial word present at reset is discarded.
- Accumulator: holds slots 0..PACK-1 and cnt 0..PACK-1.
  - ce=1 writes din into slot[cnt] and increments cnt.
- Word completion: ce=1 with cnt==PACK-1.
  - The completed word is the accumulator contents with slot[PACK-1]=din; m_cnt=PACK.
  - The word is pushed to the buffer; cnt returns to 0 and the accumulator is cleared.
- Flush: when flush=1 and (cnt>0 or ce=1), the current word is pushed.
  - If ce=1 in the same cycle, the sample is included first.
  - Unused slots read 0; m_cnt = samples held.
  - flush with cnt==0 and ce=0 is a no-op.
  - flush coinciding with completion produces one word, not two.
- Latency: m_valid rises on the cycle after the completing or flushing edge when the buffer was empty.
- Output buffer: 2-entry FIFO.
  - m_valid = not empty; m_data and m_cnt come from the head entry.
  - Pop occurs on m_valid && m_ready.
  - m_data and m_cnt stay stable while m_valid=1 and m_ready=0.
  - Words leave in order; there are no bubbles: back-to-back words with m_ready=1 give one word per cycle.
- Overflow: the buffer holds 2 entries and a push occurs without a pop in the same cycle.
  - The new word is dropped and ovf is set to 1.
  - The accumulator still clears.
  - ovf clears only on reset.
- Simultaneous push and pop with a full buffer: legal; no overflow, and the count stays at 2.
- ce is ignored for back-pressure: the packer never stalls its input.

Test Plan:
- DW=4, PACK=4, m_ready=1. Apply ce with din 1,2,3,4 -> m_valid=1 one cycle after the 4th ce; m_data=16'h4321, m_cnt=4, held for exactly one cycle.
- m_ready=0 and three words complete (16'h4321, 16'h8765, 16'hCBA9) -> ovf=1; head stays 16'h4321. Raise m_ready -> 16'h4321 then 16'h8765 are emitted; 16'hCBA9 is never emitted.
- Samples A,B then flush -> m_data=16'h00BA, m_cnt=2. A second flush with cnt=0 -> no m_valid.
- Sample 5, then flush with ce=1 and din=6 in the same cycle -> m_data=16'h0065, m_cnt=2. Next samples fill from slot 0.
- Buffer full (2 words), m_ready=1, and a word completes in the same cycle -> ovf stays 0; three words emitted in order.
- Samples 1,2,3, then rst_n=0 for 1 cycle, then samples 7,8,9,A -> a single word 16'hA987 is emitted, ovf=0, and no partial word appears.

Source files
------------

// File: rtl/sreg_sample_packer.sv
// Packs PACK consecutive ce-qualified DW-bit samples into one wide word and
// queues completed words in a 2-entry valid/ready output buffer.
module sreg_sample_packer #(
    parameter int unsigned DW   = 4,
    parameter int unsigned PACK = 4,
    parameter int unsigned CW   = $clog2(PACK + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic [DW-1:0]      din,
    input  logic               flush,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DW*PACK-1:0] m_data,
    output logic [CW-1:0]      m_cnt,
    output logic               ovf
);

    localparam int unsigned WW = DW * PACK;

    logic [WW-1:0] acc;
    logic [CW-1:0] cnt;

    logic [WW-1:0] head_data;
    logic [CW-1:0] head_cnt;
    logic          head_vld;
    logic [WW-1:0] tail_data;
    logic [CW-1:0] tail_cnt;
    logic          tail_vld;
    logic          ovf_q;

    logic [WW-1:0] word_c;
    logic [CW-1:0] word_cnt_c;
    logic          complete_c;
    logic          push_c;
    logic          pop_c;

    // Candidate word: accumulator with the current sample merged into slot[cnt]
    always_comb begin
        word_c = acc;
        if (ce) begin
            for (int i = 0; i < int'(PACK); i++) begin
                if (cnt == CW'(i)) begin
                    word_c[i*DW +: DW] = din;
                end
            end
        end
        word_cnt_c = cnt + CW'(ce);
        complete_c = ce && (cnt == CW'(PACK - 1));
        push_c     = complete_c || (flush && (ce || (cnt != '0)));
        pop_c      = head_vld && m_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            head_data <= '0;
            head_cnt  <= '0;
            head_vld  <= 1'b0;
            tail_data <= '0;
            tail_cnt  <= '0;
            tail_vld  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (push_c) begin
                acc <= '0;
                cnt <= '0;
            end else if (ce) begin
                acc <= word_c;
                cnt <= word_cnt_c;
            end

            // Head/tail buffer; a push into a full buffer without a pop is dropped
            unique case ({push_c, pop_c})
                2'b10: begin
                    if (!head_vld) begin
                        head_data <= word_c;
                        head_cnt  <= word_cnt_c;
                        head_vld  <= 1'b1;
                    end else if (!tail_vld) begin
                        tail_data <= word_c;
                        tail_cnt  <= word_cnt_c;
                        tail_vld  <= 1'b1;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_cnt  <= tail_cnt;
                    head_vld  <= tail_vld;
                    tail_vld  <= 1'b0;
                end
                2'b11: begin
                    if (tail_vld) begin
                        head_data <= tail_data;
                        head_cnt  <= tail_cnt;
                        tail_data <= word_c;
                        tail_cnt  <= word_cnt_c;
                    end else begin
                        head_data <= word_c;
                        head_cnt  <= word_cnt_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid = head_vld;
    assign m_data  = head_data;
    assign m_cnt   = head_cnt;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_sreg_sample_packer.sv
// Scoreboard bench for sreg_sample_packer (DW=4, PACK=4): a reference packer
// predicts words and drops; a negedge monitor compares each handshake.
module tb_sreg_sample_packer;

    localparam int unsigned DW   = 4;
    localparam int unsigned PACK = 4;
    localparam int unsigned CW   = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ce;
    logic [DW-1:0]      din;
    logic               flush;
    logic               m_valid;
    logic               m_ready;
    logic [DW*PACK-1:0] m_data;
    logic [CW-1:0]      m_cnt;
    logic               ovf;

    sreg_sample_packer #(.DW(DW), .PACK(PACK)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .din     (din),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_cnt   (m_cnt),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference state: {cnt, data} words still inside the DUT buffer
    logic [CW+DW*PACK-1:0] sb[$];
    logic [DW-1:0]         slots[PACK];
    int                    acnt = 0;
    logic                  exp_ovf = 1'b0;
    logic                  mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
            chk("ovf", 32'(ovf), 32'(exp_ovf));
            if (m_valid && sb.size() != 0) begin
                chk("m_data", 32'(m_data), 32'(sb[0][DW*PACK-1:0]));
                chk("m_cnt", 32'(m_cnt), 32'(sb[0][CW+DW*PACK-1:DW*PACK]));
                if (m_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic c, input logic [DW-1:0] d, input logic f,
                        input logic r, input logic rn);
        logic [DW*PACK-1:0] w;
        logic               push;
        logic               drop;
        int                 n;
        ce = c; din = d; flush = f; m_ready = r; rst_n = rn;
        w = '0;
        for (int i = 0; i < acnt; i++) w[i*DW +: DW] = slots[i];
        n = acnt;
        if (c) begin
            w[acnt*DW +: DW] = d;
            n = acnt + 1;
        end
        push = (n == int'(PACK)) || (f && n > 0);
        drop = push && sb.size() == 2 && !r;
        @(posedge clk);
        #1;
        if (!rn) begin
            sb.delete();
            acnt = 0;
            exp_ovf = 1'b0;
        end else if (push) begin
            acnt = 0;
            if (drop) exp_ovf = 1'b1;
            else sb.push_back({CW'(n), w});
        end else if (c) begin
            slots[acnt] = d;
            acnt = n;
        end
    endtask

    task automatic samples(input logic [DW-1:0] first, input int num, input logic r);
        logic [DW-1:0] v;
        v = first;
        for (int i = 0; i < num; i++) begin
            step(1'b1, v, 1'b0, r, 1'b1);
            v = v + DW'(1);
        end
    endtask

    task automatic idle(input int num, input logic r);
        for (int i = 0; i < num; i++) step(1'b0, '0, 1'b0, r, 1'b1);
    endtask

    initial begin
        ce = 1'b0; din = '0; flush = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;

        // Single word 4321, one-cycle valid with ready high
        samples(4'h1, 4, 1'b1);
        idle(3, 1'b1);

        // Three words under backpressure: third is dropped, ovf set
        samples(4'h1, 12, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Partial flush A,B then a no-op flush
        samples(4'hA, 2, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Flush together with a sample, then refill from slot 0
        samples(4'h5, 1, 1'b1);
        step(1'b1, 4'h6, 1'b1, 1'b1, 1'b1);
        samples(4'h1, 4, 1'b1);
        idle(2, 1'b1);

        // Full buffer with a simultaneous pop and completion: no overflow
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        samples(4'h1, 11, 1'b0);
        samples(4'hC, 1, 1'b1);
        idle(4, 1'b1);

        // Partial word discarded by reset
        samples(4'h1, 3, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        samples(4'h7, 4, 1'b1);
        idle(3, 1'b1);

        // Random traffic including flush and backpressure
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 2) != 0), 1'b1);
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1, 1'b1);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
